// File: rtl/alu4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu4_pkg
// Description : Shared types and constants for the 4-bit ALU and its
//               multi-nibble sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu4_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;

endpackage : alu4_pkg
`default_nettype wire

// File: rtl/alu4_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu4_seq_if
// Description : Command / response bundle of the multi-nibble ALU sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu4_seq_if
    import alu4_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIBBLE_W * NIBBLES;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_op;
    logic           cmd_msb_first;
    logic           cmd_mc;
    logic           cmd_rc;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_y;
    logic           rsp_mc;
    logic           rsp_rc;
    logic           rsp_ovf;
    logic           rsp_zero;

    modport master (
        output cmd_valid, cmd_op, cmd_msb_first, cmd_mc, cmd_rc, cmd_a, cmd_b,
        input  cmd_ready,
        input  rsp_valid, rsp_y, rsp_mc, rsp_rc, rsp_ovf, rsp_zero,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_msb_first, cmd_mc, cmd_rc, cmd_a, cmd_b,
        output cmd_ready,
        output rsp_valid, rsp_y, rsp_mc, rsp_rc, rsp_ovf, rsp_zero,
        input  rsp_ready
    );

endinterface : alu4_seq_if
`default_nettype wire

// File: rtl/alu4.sv
`default_nettype none
// ============================================================================
// Module      : alu4
// Description : Combinational 4-bit ALU with chained math and rotate carries.
// Revision    : 1.0 - initial release
// ============================================================================
module alu4
    import alu4_pkg::*;
(
    input  wire logic [3:0] i_a,
    input  wire logic [3:0] i_b,
    input  wire logic [3:0] i_op,
    input  wire logic       i_mc,
    input  wire logic       i_rc,
    output logic      [3:0] o_y,
    output logic            o_mc,
    output logic            o_rc,
    output logic            o_ovf,
    output logic            o_zero
);

    logic [4:0] w_sum;

    // Logical ops pass both carries through so a chained word keeps them intact.
    always_comb begin
        w_sum = 5'd0;
        o_y   = 4'd0;
        o_mc  = i_mc;
        o_rc  = i_rc;
        o_ovf = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_mc};
                o_y   = w_sum[3:0];
                o_mc  = w_sum[4];
                o_ovf = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
            end
            OP_SUB: begin
                w_sum = {1'b0, i_a} - {1'b0, i_b} - {4'd0, i_mc};
                o_y   = w_sum[3:0];
                o_mc  = w_sum[4];
                o_ovf = (i_a[3] != i_b[3]) && (w_sum[3] != i_a[3]);
            end
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_XOR: o_y = i_a ^ i_b;
            OP_SHL: begin
                o_y  = {i_a[2:0], i_rc};
                o_rc = i_a[3];
            end
            OP_ROR: begin
                o_y  = {i_rc, i_a[3:1]};
                o_rc = i_a[0];
            end
            default: o_y = 4'd0;
        endcase
    end

    assign o_zero = (o_y == 4'd0);

endmodule : alu4
`default_nettype wire

// File: rtl/alu4_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu4_seq
// Description : Drives a 4-bit ALU one nibble per clock to execute a wide
//               operation; optional abort port under ALU4_SEQ_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu4_seq
    import alu4_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    alu4_seq_if.slave       bus,
    output logic      [3:0] alu_a,
    output logic      [3:0] alu_b,
    output logic      [3:0] alu_op,
    output logic            alu_mc_in,
    output logic            alu_rc_in,
    input  wire logic [3:0] alu_y,
    input  wire logic       alu_mc_out,
    input  wire logic       alu_rc_out,
    input  wire logic       alu_ovf,
    input  wire logic       alu_zero
`ifdef ALU4_SEQ_ABORT_EN
    ,
    input  wire logic       abort
`endif
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] c_IDX_FIRST = '0;
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(NIBBLES - 1);

    state_t                               r_state;
    state_t                               w_state_nxt;
    logic [3:0]                           r_op;
    logic                                 r_msb;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]     r_a;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]     r_b;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]     r_y;
    logic                                 r_mc;
    logic                                 r_rc;
    logic                                 r_ovf;
    logic                                 r_zacc;
    logic [IDX_W-1:0]                     r_idx;
    logic                                 w_last;
    logic                                 w_accept;
    logic                                 w_step;
    logic                                 w_abort;

`ifdef ALU4_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Termination is an explicit compare against the direction's end index.
    assign w_last = (r_idx == (r_msb ? c_IDX_FIRST : c_IDX_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_step        = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        alu_a         = 4'd0;
        alu_b         = 4'd0;
        alu_op        = 4'd0;
        alu_mc_in     = 1'b0;
        alu_rc_in     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                alu_a     = r_a[r_idx];
                alu_b     = r_b[r_idx];
                alu_op    = r_op;
                alu_mc_in = r_mc;
                alu_rc_in = r_rc;
                if (w_abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= 4'd0;
            r_msb  <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_y    <= '0;
            r_mc   <= 1'b0;
            r_rc   <= 1'b0;
            r_ovf  <= 1'b0;
            r_zacc <= 1'b1;
            r_idx  <= '0;
        end else if (w_accept) begin
            r_op   <= bus.cmd_op;
            r_msb  <= bus.cmd_msb_first;
            r_a    <= bus.cmd_a;
            r_b    <= bus.cmd_b;
            r_mc   <= bus.cmd_mc;
            r_rc   <= bus.cmd_rc;
            r_zacc <= 1'b1;
            r_idx  <= bus.cmd_msb_first ? c_IDX_LAST : c_IDX_FIRST;
        end else if (w_step) begin
            r_y[r_idx] <= alu_y;
            r_mc       <= alu_mc_out;
            r_rc       <= alu_rc_out;
            r_ovf      <= alu_ovf;
            r_zacc     <= r_zacc & alu_zero;
            if (!w_last) begin
                r_idx <= r_msb ? (r_idx - 1'b1) : (r_idx + 1'b1);
            end
        end
    end

    assign bus.rsp_y    = r_y;
    assign bus.rsp_mc   = r_mc;
    assign bus.rsp_rc   = r_rc;
    assign bus.rsp_ovf  = r_ovf;
    assign bus.rsp_zero = r_zacc;

endmodule : alu4_seq
`default_nettype wire

// File: tb/tb_alu4_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu4_seq
// Description : Self-checking bench for alu4_seq paired with alu4; abort
//               scenarios are compiled in with ALU4_SEQ_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu4_seq;
    import alu4_pkg::*;

    localparam int N = 4;
    localparam int W = N * NIBBLE_W;

    typedef struct packed {
        logic [W-1:0] y;
        logic         mc;
        logic         rc;
        logic         ovf;
        logic         zero;
    } rsp_t;

    typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic [3:0] alu_a, alu_b, alu_op, alu_y;
    logic       alu_mc_in, alu_rc_in, alu_mc_out, alu_rc_out, alu_ovf, alu_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu4_seq_if #(.NIBBLES(N)) bus ();

    alu4_seq #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_mc_in  (alu_mc_in),
        .alu_rc_in  (alu_rc_in),
        .alu_y      (alu_y),
        .alu_mc_out (alu_mc_out),
        .alu_rc_out (alu_rc_out),
        .alu_ovf    (alu_ovf),
        .alu_zero   (alu_zero)
`ifdef ALU4_SEQ_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    alu4 u_alu (
        .i_a    (alu_a),
        .i_b    (alu_b),
        .i_op   (alu_op),
        .i_mc   (alu_mc_in),
        .i_rc   (alu_rc_in),
        .o_y    (alu_y),
        .o_mc   (alu_mc_out),
        .o_rc   (alu_rc_out),
        .o_ovf  (alu_ovf),
        .o_zero (alu_zero)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Whole-word reference: what a chained nibble pass must add up to.
    function automatic rsp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic mc, input logic rc);
        rsp_t     r;
        logic [W:0] t;
        r.y = '0; r.mc = mc; r.rc = rc; r.ovf = 1'b0;
        t = '0;
        case (op)
            OP_ADD: begin
                t = {1'b0, a} + {1'b0, b} + (W+1)'(mc);
                r.y = t[W-1:0]; r.mc = t[W];
                r.ovf = (a[W-1] == b[W-1]) && (r.y[W-1] != a[W-1]);
            end
            OP_SUB: begin
                t = {1'b0, a} - {1'b0, b} - (W+1)'(mc);
                r.y = t[W-1:0]; r.mc = t[W];
                r.ovf = (a[W-1] != b[W-1]) && (r.y[W-1] != a[W-1]);
            end
            OP_AND: r.y = a & b;
            OP_OR:  r.y = a | b;
            OP_XOR: r.y = a ^ b;
            OP_SHL: begin r.y = {a[W-2:0], rc}; r.rc = a[W-1]; end
            OP_ROR: begin r.y = {rc, a[W-1:1]}; r.rc = a[0]; end
            default: r.y = '0;
        endcase
        r.zero = (r.y == '0);
        return r;
    endfunction

    // Cycle-level protocol tracker and per-cycle compare.
    mst_t       m_st = M_IDLE;
    int         m_k = 0;
    int         m_ix = 0;
    bit         m_armed = 1'b0;
    logic [3:0] m_op = '0;
    logic       m_msb = 1'b0, m_mc = 1'b0, m_rc = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    rsp_t       m_exp = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_st = M_IDLE;
                m_armed = 1'b1;
            end else begin
                case (m_st)
                    M_IDLE: if (bus.cmd_valid) begin
                        m_st = M_RUN; m_k = 0;
                        m_op = bus.cmd_op; m_msb = bus.cmd_msb_first;
                        m_a = bus.cmd_a; m_b = bus.cmd_b; m_mc = bus.cmd_mc; m_rc = bus.cmd_rc;
                        m_exp = model(m_op, m_a, m_b, m_mc, m_rc);
                    end
                    M_RUN: if (abort) m_st = M_IDLE;
                           else begin
                               m_k++;
                               if (m_k == N) m_st = M_DONE;
                           end
                    M_DONE: if (bus.rsp_ready) m_st = M_IDLE;
                    default: m_st = M_IDLE;
                endcase
            end
            #1;
            if (m_armed) begin
                chk("mon cmd_ready", bus.cmd_ready, m_st == M_IDLE);
                chk("mon rsp_valid", bus.rsp_valid, m_st == M_DONE);
                if (m_st == M_RUN) begin
                    m_ix = m_msb ? (N - 1 - m_k) : m_k;
                    chk("mon alu_a", alu_a, m_a[m_ix*4 +: 4]);
                    chk("mon alu_b", alu_b, m_b[m_ix*4 +: 4]);
                    chk("mon alu_op", alu_op, m_op);
                    if (m_k == 0) chk("mon alu carry in", {alu_mc_in, alu_rc_in}, {m_mc, m_rc});
                end else begin
                    chk("mon alu idle", {alu_a, alu_b, alu_op, alu_mc_in, alu_rc_in}, 32'd0);
                end
                if (m_st == M_DONE)
                    chk("mon rsp", {bus.rsp_y, bus.rsp_mc, bus.rsp_rc, bus.rsp_ovf, bus.rsp_zero}, m_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [3:0] op, input logic msb, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic mc, input logic rc);
        int g = 0;
        bus.cmd_op = op; bus.cmd_msb_first = msb; bus.cmd_a = a; bus.cmd_b = b;
        bus.cmd_mc = mc; bus.cmd_rc = rc; bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && g < 40) begin tick(); g++; end
        chk("accept timeout", g < 40, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input int exp_lat);
        int lat = 0;
        while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
        chk({nm, " latency"}, lat, exp_lat);
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_cmd(input string nm, input logic [3:0] op, input logic msb,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic mc, input logic rc,
                          input logic [W-1:0] ey, input logic emc, input logic erc,
                          input logic eovf, input logic ez);
        rsp_t lit;
        lit = {ey, emc, erc, eovf, ez};
        chk({nm, " model"}, model(op, a, b, mc, rc), lit);
        issue(op, msb, a, b, mc, rc);
        wait_rsp(nm, N);
        chk({nm, " rsp"}, {bus.rsp_y, bus.rsp_mc, bus.rsp_rc, bus.rsp_ovf, bus.rsp_zero}, lit);
        handshake();
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_msb_first = 1'b0;
        bus.cmd_mc = 1'b0; bus.cmd_rc = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset cmd_ready", bus.cmd_ready, 1);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset alu", {alu_a, alu_b, alu_op, alu_mc_in, alu_rc_in}, 32'd0);

        //      name        op      msb  a         b         mc    rc    y         mc rc ovf z
        do_cmd("add carry", OP_ADD, 1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 0, 0, 0, 0);
        do_cmd("add wrap",  OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1, 0, 0, 1);
        do_cmd("ror one",   OP_ROR, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0000, 0, 1, 0, 1);
        do_cmd("ror msb",   OP_ROR, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 16'hC000, 0, 0, 0, 0);
        do_cmd("sub borrow",OP_SUB, 1'b0, 16'h1000, 16'h0001, 1'b0, 1'b0, 16'h0FFF, 0, 0, 0, 0);
        do_cmd("sub neg",   OP_SUB, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1, 0, 0, 0);
        do_cmd("sub bin",   OP_SUB, 1'b0, 16'h0005, 16'h0002, 1'b1, 1'b0, 16'h0002, 0, 0, 0, 0);
        do_cmd("sub ovf",   OP_SUB, 1'b0, 16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 0, 0, 1, 0);
        do_cmd("add ovf",   OP_ADD, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 0, 0, 1, 0);
        do_cmd("xor msb",   OP_XOR, 1'b1, 16'hA5A5, 16'hFFFF, 1'b0, 1'b0, 16'h5A5A, 0, 0, 0, 0);
        do_cmd("shl",       OP_SHL, 1'b0, 16'h8001, 16'h0000, 1'b0, 1'b1, 16'h0003, 0, 1, 0, 0);
        do_cmd("and pass",  OP_AND, 1'b0, 16'hF0F0, 16'h0FF0, 1'b1, 1'b1, 16'h00F0, 1, 1, 0, 0);

        // Backpressure with a second command waiting.
        issue(OP_ADD, 1'b0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_rsp("bp first", N);
        bus.cmd_op = OP_SUB; bus.cmd_a = 16'h5000; bus.cmd_b = 16'h0001;
        bus.cmd_mc = 1'b0; bus.cmd_rc = 1'b0; bus.cmd_msb_first = 1'b0; bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp rsp_y stable", bus.rsp_y, 16'h2345);
            chk("bp rsp_valid", bus.rsp_valid, 1);
            chk("bp cmd_ready", bus.cmd_ready, 0);
        end
        handshake();
        chk("bp after hs rsp_valid", bus.rsp_valid, 0);
        chk("bp after hs cmd_ready", bus.cmd_ready, 1);
        tick();
        chk("bp second accepted", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        wait_rsp("bp second", N);
        chk("bp second rsp_y", bus.rsp_y, 16'h4FFF);
        handshake();

        // Reset pulse during the second run cycle.
        issue(OP_ADD, 1'b0, 16'h0F0F, 16'h0101, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst cmd_ready", bus.cmd_ready, 1);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst alu", {alu_a, alu_b, alu_op, alu_mc_in, alu_rc_in}, 32'd0);
        for (int i = 0; i < N + 3; i++) begin
            tick();
            chk("rst no rsp", bus.rsp_valid, 0);
        end

`ifdef ALU4_SEQ_ABORT_EN
        issue(OP_ADD, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort cmd_ready", bus.cmd_ready, 1);
        chk("abort rsp_valid", bus.rsp_valid, 0);
        for (int i = 0; i < N + 2; i++) begin
            tick();
            chk("abort no rsp", bus.rsp_valid, 0);
        end
        issue(OP_ADD, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_rsp("abort done", N);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort done rsp_valid", bus.rsp_valid, 1);
        chk("abort done rsp_y", bus.rsp_y, 16'h3333);
        handshake();
`endif

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_alu4_seq
`default_nettype wire

// File: doc/alu4_seq.md
# alu4_seq

Multi-nibble sequencer for the 4-bit ALU. It accepts one wide operation (NIBBLES×4 bits) per command and drives the combinational ALU one nibble per clock. Math and rotate carries are chained between nibbles, and the zero flag is accumulated across the whole word. The block sits between the command source and the ALU instance, and returns a single wide result with flags on a valid/ready response port.

## Interface
- NIBBLES, 4, operand width in nibbles (W = 4×NIBBLES); legal range 2..8
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  4  ALU opcode, forwarded unchanged
- cmd_msb_first  in  1  1 = process nibbles high→low (right rotate/shift); 0 = low→high
- cmd_mc, cmd_rc  in  1 each  initial math / rotate carry
- cmd_a, cmd_b  in  W  operands
- alu_a, alu_b  out  4  current nibble to ALU
- alu_op  out  4  opcode to ALU
- alu_mc_in, alu_rc_in  out  1 each  chained carries to ALU
- alu_y  in  4  ALU result nibble
- alu_mc_out, alu_rc_out, alu_ovf, alu_zero  in  1 each  ALU flags
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_y  out  W  result word
- rsp_mc, rsp_rc, rsp_ovf, rsp_zero  out  1 each  final flags
- abort  in  1  present only with ALU4_SEQ_ABORT_EN

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: cmd_ready=1. When cmd_valid=1, latch op, dir, a, b, mc and rc. Set idx to 0 (LSB-first) or NIBBLES-1 (MSB-first). Set zacc=1. Go to RUN.
- RUN: drive alu_a=a[idx], alu_b=b[idx], alu_op=op, alu_mc_in=mc_reg, alu_rc_in=rc_reg.
- RUN, each edge: y[idx]←alu_y; mc_reg←alu_mc_out; rc_reg←alu_rc_out; ovf_reg←alu_ovf; zacc←zacc&alu_zero; idx steps ±1.
- RUN, after the last nibble (idx reached the end): go to DONE.
- DONE: rsp_valid=1, and rsp_* are driven from the registers. When rsp_ready=1, go to IDLE.
- cmd_ready is 0 in RUN and DONE. cmd_valid is ignored outside IDLE.
- Outside RUN, alu_a, alu_b, alu_op and the ALU carry outputs are forced to 0.
- rsp_ovf is the overflow of the last processed nibble. It is meaningful only for LSB-first arithmetic; it is not masked otherwise.
- The sequencer never inspects cmd_op. Carry semantics belong entirely to the ALU.
- idx width: $clog2(NIBBLES). No wrap: termination is an explicit compare against the end index.

## Timing
- Reset: state=IDLE; idx, y, mc_reg, rc_reg, ovf_reg = 0; zacc=1.
- Output values at reset: cmd_ready reads 1 from the first cycle after the reset edge; rsp_valid=0; all alu_* outputs = 0.
- rst overrides everything. Asserting it mid-RUN or in DONE discards the operation, and no response is produced.
- Accept at edge k → RUN occupies cycles k..k+NIBBLES-1 → rsp_valid=1 from edge k+NIBBLES.
- Minimum command period is NIBBLES+2 cycles: accept, NIBBLES run cycles, then one DONE cycle with rsp_ready=1.
- rsp_valid and rsp_* hold stable while rsp_ready=0. They drop at the edge where rsp_valid&rsp_ready.
- The ALU path is combinational within a RUN cycle. Timing closure budget is one ALU delay plus mux.

## Configuration
- ALU4_SEQ_ABORT_EN defined: abort port exists.
  - abort=1 in RUN → IDLE at the next edge; rsp_valid stays 0 and partial results are discarded.
  - abort in IDLE or DONE is ignored.
- ALU4_SEQ_ABORT_EN undefined: no abort port; RUN always completes.

## Structure
- Shared package alu4_pkg holds: state enum (IDLE, RUN, DONE), the ALU opcode constants (OP_ADD, OP_SUB, OP_SHL, OP_ROR, …), and NIBBLE_W=4.
- Single module. No sub-module is needed; the ALU is instantiated by the parent and connected via alu_*.
- The bench pairs alu4_seq with the real ALU.

## Test plan
- OP_ADD, a=0x00FF, b=0x0001, mc=0, LSB-first → rsp_y=0x0100, rsp_mc=0, rsp_zero=0, rsp_valid exactly 4 edges after accept.
- OP_ADD, a=0xFFFF, b=0x0001, mc=0 → rsp_y=0x0000, rsp_mc=1, rsp_zero=1, rsp_ovf=0.
- OP_ROR, a=0x0001, rc=0, MSB-first → rsp_y=0x0000, rsp_rc=1. Repeat with a=0x8000, rc=1 → rsp_y=0xC000, rsp_rc=0.
- Backpressure: hold rsp_ready=0 for 10 cycles while cmd_valid=1 with a new command → rsp_* stable, cmd_ready=0, second command accepted only the cycle after the response handshake.
- rst pulse during nibble 2 of RUN → next cycle IDLE, cmd_ready=1, rsp_valid=0, alu_*=0, and no response ever appears.
- With ALU4_SEQ_ABORT_EN: abort during nibble 1 → IDLE next edge, no rsp_valid. Abort during DONE → response still delivered.
